byte_packer: RTL
================

# byte_packer

Downstream consumer for the 8-bit free-running data/valid source. It collects every byte presented with `in_valid` and packs four consecutive bytes into one 32-bit word. Completed words are buffered in a small FIFO and offered on a valid/ready output handshake. The source has no backpressure, so words that arrive while the FIFO is full are dropped and flagged with a sticky overflow flag.

## Interface
- `DEPTH`, 4: FIFO depth in 32-bit words. Must be a power of two and ≥2.
- `clock`  input  1  sole clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_data`  input  8  byte from the upstream source; sampled only when `in_valid`=1.
- `in_valid`  input  1  byte qualifier; may be high on consecutive cycles; the block never stalls it.
- `out_data`  output  32  packed word at the FIFO head.
- `out_valid`  output  1  FIFO non-empty.
- `out_ready`  input  1  consumer accepts the word when `out_valid`=1 on the same edge.
- `level`  output  $clog2(DEPTH)+1  number of words currently in the FIFO.
- `overflow`  output  1  sticky; set when a completed word is dropped.

## Operation
- Byte slot counter `slot`, 2 bits, resets to 0, and a 24-bit partial register.
  - Each sampled byte is written into lane `slot`: lane 0 is bits [7:0], lane 3 is bits [31:24], so the first byte lands in the LSB.
  - `slot` increments modulo 4 on every sampled byte.
- Word completion: a byte sampled with `slot`=3 completes the word {in_data, partial[23:0]}.
  - The completed word is pushed into the FIFO on that same edge.
  - `slot` wraps to 0 whether or not the push succeeds.
- Pop: occurs when `out_valid`=1 and `out_ready`=1 at an edge; the head advances.
- Push/pop arbitration, per edge:
  - Push only: `level` increases by 1.
  - Pop only: `level` decreases by 1.
  - Push and pop together: `level` is unchanged, and the push is accepted even when `level`=DEPTH, because the pop frees a slot on the same edge.
  - Push while `level`=DEPTH and no pop: the word is discarded and `overflow` is set to 1. FIFO contents are untouched.
- `overflow` is cleared only by `reset`.
- FIFO storage: circular buffer with read and write pointers of $clog2(DEPTH) bits, which wrap naturally. Full and empty are derived from `level`.
- `out_data` is the head entry, read combinationally from storage. It is stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-operation:
  - Partial bytes are discarded and `slot` returns to 0.
  - Pointers and `level` return to 0 and `overflow` to 0.
  - A pop or push requested on the reset edge is ignored.
- `out_ready` while `out_valid`=0 has no effect.

## Timing
- Reset values:
  - `out_valid`=0, `level`=0, `overflow`=0.
  - `out_data` is don't-care while `out_valid`=0; the bench must not check it.
- Latency: 4th byte sampled at edge N. If the FIFO was empty, `out_valid`=1 and `out_data` holds the word in the cycle after edge N.
- Throughput:
  - Input: one byte per cycle sustained.
  - Output: one word per cycle.
  - A full-rate input needs only 1 pop per 4 cycles to avoid overflow.
- `level` and `overflow` are registered and update on the edge that causes the change.
- No combinational path from `out_ready` to `out_valid` or `out_data`.

## Test plan
- **Reset values:**
  - Stimulus: assert `reset` for 2 cycles with `in_valid`=1.
  - Required: `out_valid`=0, `level`=0, `overflow`=0, and no word appears afterwards until 4 post-reset bytes have been sampled.
- **Packing order and latency:**
  - Stimulus: bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `out_ready`=0.
  - Required: one cycle after the 0x44 edge, `out_valid`=1, `out_data`=0x44332211, `level`=1.
- **Sparse input:**
  - Stimulus: bytes 0xA0..0xA7 with `in_valid` pulsing once every 8 cycles (source-style spacing), `out_ready`=1.
  - Required: words 0xA3A2A1A0 then 0xA7A6A5A4, each with `out_valid` high for exactly 1 cycle.
- **Fill, overflow, and simultaneous push/pop at full** (DEPTH=4):
  - Stimulus: 20 bytes 0x00..0x13 back-to-back with `out_ready`=0.
  - Required: `level` saturates at 4 and `overflow`=1. Draining yields 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, so word 0x13121110 was dropped.
  - Second run: repeat with `out_ready` pulsed on the exact edge the 5th word completes. Required: no overflow, `level` stays 4, and the 5th word is delivered last.
- **Reset mid-word:**
  - Stimulus: bytes 0x01, 0x02, then reset, then 0x10, 0x20, 0x30, 0x40.
  - Required: the only word output is 0x40302010.
- **Backpressure hold:**
  - Stimulus: two words queued, `out_ready` toggling 0,0,1,0,1.
  - Required: `out_data` holds each word unchanged while not accepted, `level` steps 2→1→0 only on the accepting edges, and the pointers wrap correctly after more than DEPTH total pushes.

Source files
------------

// File: rtl/byte_packer.sv
// byte_packer: packs four consecutive sampled bytes (first byte in the LSB lane)
// into a 32-bit word and queues completed words in a small circular FIFO with a
// valid/ready output. Words completing while the FIFO is full and not popping
// on the same edge are dropped and latched into a sticky overflow flag.
module byte_packer #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [1:0]    slot_q, slot_d;
  logic [23:0]   partial_q, partial_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic          wordDone;
  logic [31:0]   completedWord;
  logic          full;
  logic          pop;
  logic          push;

  assign wordDone      = in_valid && (slot_q == 2'd3);
  assign completedWord = {in_data, partial_q};
  assign full          = (level_q == LW'(DEPTH));
  assign pop           = out_valid && out_ready;
  assign push          = wordDone && (!full || pop);

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rdPtr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;

  // Lane steering: bytes for slots 0..2 are parked; slot 3 completes the word directly from in_data.
  always_comb begin
    partial_d = partial_q;
    slot_d    = slot_q;
    if (in_valid) begin
      slot_d = slot_q + 2'd1;
      case (slot_q)
        2'd0:    partial_d[7:0]   = in_data;
        2'd1:    partial_d[15:8]  = in_data;
        2'd2:    partial_d[23:16] = in_data;
        default: partial_d        = partial_q;
      endcase
    end
  end

  // FIFO bookkeeping: a pop on the same edge frees room, so push at full is allowed then.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (wordDone && !push) overflow_d = 1'b1;
  end

  // Control state registers; reset discards partial bytes, queued words and the sticky flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q     <= 2'd0;
      partial_q  <= 24'd0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      partial_q  <= partial_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage needs no reset because out_valid masks stale entries.
  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wrPtr_q] <= completedWord;
  end

endmodule
